// File: rtl/seq_pkg.sv
// Shared symbol definitions for the 4-symbol sequence generator and checker.
// Holds the legal symbol constants, the checker FSM states and the successor function.
package seq_pkg;

  typedef logic [2:0] sym_t;

  localparam sym_t S0 = 3'b000;
  localparam sym_t S1 = 3'b010;
  localparam sym_t S2 = 3'b011;
  localparam sym_t S3 = 3'b101;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    VERIFY  = 2'd1,
    LOCK    = 2'd2,
    SUSPECT = 2'd3
  } state_t;

  // Successor in the legal cycle; anything illegal restarts at S0.
  function automatic sym_t next_sym(input sym_t s);
    case (s)
      S0:      return S1;
      S1:      return S2;
      S2:      return S3;
      S3:      return S0;
      default: return S0;
    endcase
  endfunction

  function automatic logic is_legal(input sym_t s);
    return (s == S0) || (s == S1) || (s == S2) || (s == S3);
  endfunction

endpackage

// File: rtl/sequence_checker_if.sv
// Symbol stream in, lock/error status out; the checker is the slave side.
interface sequence_checker_if #(
  parameter int ERR_W = 8,
  parameter int CYC_W = 8
);
  logic [2:0]       in;
  logic             in_valid;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_count;
  logic [CYC_W-1:0] cyc_count;

  modport master (
    output in, in_valid,
    input  locked, err, err_count, cyc_count
  );

  modport slave (
    input  in, in_valid,
    output locked, err, err_count, cyc_count
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/sequence_checker.sv
// Tracks the S0->S1->S2->S3 symbol cycle, tolerating one isolated error while locked,
// and reports lock status, error pulses, a saturating error count and a cycle count.
module sequence_checker
  import seq_pkg::*;
#(
  parameter int ERR_W = 8,
  parameter int CYC_W = 8
) (
  input logic               clk,
  input logic               rst,
  sequence_checker_if.slave bus
);

  state_t           state, state_nxt;
  sym_t             exp_q, exp_nxt;
  logic             err_q, err_nxt;
  logic             err_inc;
  logic             cyc_inc;
  logic [CYC_W-1:0] cyc_q;
  logic [ERR_W-1:0] err_cnt;
  sym_t             sym;
  logic             match;

  assign sym   = bus.in;
  assign match = (sym == exp_q);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= HUNT;
      exp_q <= S0;
      err_q <= 1'b0;
      cyc_q <= '0;
    end else begin
      state <= state_nxt;
      exp_q <= exp_nxt;
      err_q <= err_nxt;
      if (cyc_inc) cyc_q <= cyc_q + CYC_W'(1);
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_nxt = state;
    exp_nxt   = exp_q;
    err_nxt   = 1'b0;
    err_inc   = 1'b0;
    cyc_inc   = 1'b0;
    if (bus.in_valid) begin
      case (state)
        HUNT: begin
          if (is_legal(sym)) begin
            exp_nxt   = next_sym(sym);
            state_nxt = VERIFY;
          end
        end
        VERIFY: begin
          // Entering LOCK never counts a cycle, even on an S0 match.
          if (match) begin
            exp_nxt   = next_sym(exp_q);
            state_nxt = LOCK;
          end else if (is_legal(sym)) begin
            exp_nxt = next_sym(sym);
          end else begin
            state_nxt = HUNT;
          end
        end
        LOCK: begin
          exp_nxt = next_sym(exp_q);
          if (match) begin
            cyc_inc = (sym == S0);
          end else begin
            state_nxt = SUSPECT;
            err_nxt   = 1'b1;
            err_inc   = 1'b1;
          end
        end
        SUSPECT: begin
          if (match) begin
            exp_nxt   = next_sym(exp_q);
            state_nxt = LOCK;
            cyc_inc   = (sym == S0);
          end else begin
            state_nxt = HUNT;
            err_nxt   = 1'b1;
            err_inc   = 1'b1;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  sat_counter #(.W(ERR_W)) u_err_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .clr   (1'b0),
    .count (err_cnt)
  );

  // Output logic, decoded from registered state only.
  always_comb begin
    bus.locked    = (state == LOCK) || (state == SUSPECT);
    bus.err       = err_q;
    bus.err_count = err_cnt;
    bus.cyc_count = cyc_q;
  end

endmodule

// File: tb/tb_sequence_checker.sv
// Directed-vector bench for sequence_checker; a second instance with ERR_W=2
// shares the stimulus and is used for the saturation scenario.
module tb_sequence_checker;
  import seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sym;
  logic       vld;
  int         checks = 0;
  int         errors = 0;

  sequence_checker_if #(.ERR_W(8), .CYC_W(8)) bus  ();
  sequence_checker_if #(.ERR_W(2), .CYC_W(8)) bus2 ();

  assign bus.in        = sym;
  assign bus.in_valid  = vld;
  assign bus2.in       = sym;
  assign bus2.in_valid = vld;

  sequence_checker #(.ERR_W(8), .CYC_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sequence_checker #(.ERR_W(2), .CYC_W(8)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  always #5 clk = ~clk;

  // Present one symbol before the edge, return 1 time unit after it.
  task automatic send(input logic [2:0] s, input logic v);
    @(negedge clk);
    sym = s;
    vld = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    vld = 1'b0;
    sym = 3'b000;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    vld = 1'b0;
    sym = 3'b111;
    #1;
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", bus.locked); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d expected 0", bus.err_count); end
    checks++; if (bus.cyc_count !== 8'd0) begin errors++; $display("FAIL reset_cyc_count: got %0d expected 0", bus.cyc_count); end
    checks++; if (dut.state !== HUNT) begin errors++; $display("FAIL reset_state: got %0d expected HUNT", dut.state); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_lock_and_cycle();
    do_reset();
    send(3'b000, 1'b1);
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL lock_after_s0: got %b expected 0", bus.locked); end
    send(3'b010, 1'b1);
    checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL lock_after_s1: got %b expected 1", bus.locked); end
    send(3'b011, 1'b1);
    send(3'b101, 1'b1);
    checks++; if (bus.cyc_count !== 8'd0) begin errors++; $display("FAIL cyc_before_wrap: got %0d expected 0", bus.cyc_count); end
    send(3'b000, 1'b1);
    checks++; if (bus.cyc_count !== 8'd1) begin errors++; $display("FAIL cyc_after_s0: got %0d expected 1", bus.cyc_count); end
    checks++; if (bus.err !== 1'b0 || bus.err_count !== 8'd0) begin errors++; $display("FAIL lock_no_err: got err=%b cnt=%0d expected 0/0", bus.err, bus.err_count); end
  endtask

  // Continues from test_lock_and_cycle: locked, expecting 010.
  task automatic test_single_error();
    send(3'b010, 1'b1);
    send(3'b111, 1'b1);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL single_err_pulse: got %b expected 1", bus.err); end
    checks++; if (bus.err_count !== 8'd1) begin errors++; $display("FAIL single_err_count: got %0d expected 1", bus.err_count); end
    checks++; if (bus.locked !== 1'b1 || dut.state !== SUSPECT) begin errors++; $display("FAIL single_suspect: got locked=%b state=%0d expected 1/SUSPECT", bus.locked, dut.state); end
    send(3'b101, 1'b1);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL single_err_clear: got %b expected 0", bus.err); end
    checks++; if (dut.state !== LOCK || bus.locked !== 1'b1) begin errors++; $display("FAIL single_relock: got state=%0d locked=%b expected LOCK/1", dut.state, bus.locked); end
  endtask

  // Continues: locked, expecting 000.
  task automatic test_idle();
    for (int i = 0; i < 5; i++) begin
      send(3'b111, 1'b0);
      checks++; if (bus.err !== 1'b0 || bus.locked !== 1'b1 || dut.state !== LOCK) begin errors++; $display("FAIL idle_hold_%0d: got err=%b locked=%b state=%0d expected 0/1/LOCK", i, bus.err, bus.locked, dut.state); end
    end
    send(3'b000, 1'b1);
    checks++; if (bus.cyc_count !== 8'd2 || bus.err !== 1'b0) begin errors++; $display("FAIL idle_resume: got cyc=%0d err=%b expected 2/0", bus.cyc_count, bus.err); end
  endtask

  task automatic test_double_error();
    do_reset();
    send(3'b000, 1'b1);
    send(3'b010, 1'b1);
    send(3'b111, 1'b1);
    checks++; if (bus.err !== 1'b1 || bus.err_count !== 8'd1) begin errors++; $display("FAIL double_first: got err=%b cnt=%0d expected 1/1", bus.err, bus.err_count); end
    send(3'b111, 1'b1);
    checks++; if (bus.err !== 1'b1 || bus.err_count !== 8'd2) begin errors++; $display("FAIL double_second: got err=%b cnt=%0d expected 1/2", bus.err, bus.err_count); end
    checks++; if (bus.locked !== 1'b0 || dut.state !== HUNT) begin errors++; $display("FAIL double_unlock: got locked=%b state=%0d expected 0/HUNT", bus.locked, dut.state); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [5];
    logic [2:0] pat [8];
    int         v;
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    pat     = '{3'b000, 3'b010, 3'b111, 3'b111, 3'b000, 3'b010, 3'b111, 3'b111};
    do_reset();
    v = 0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 8; k++) begin
        if (v < 5) begin
          send(pat[k], 1'b1);
          if (pat[k] == 3'b111) begin
            checks++; if (bus2.err !== 1'b1 || bus2.err_count !== exp_cnt[v]) begin errors++; $display("FAIL sat_violation_%0d: got err=%b cnt=%0d expected 1/%0d", v, bus2.err, bus2.err_count, exp_cnt[v]); end
            v++;
          end
        end
      end
    end
    checks++; if (bus.err_count !== 8'd5) begin errors++; $display("FAIL sat_wide_count: got %0d expected 5", bus.err_count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    send(3'b000, 1'b1);
    send(3'b010, 1'b1);
    send(3'b011, 1'b1);
    send(3'b101, 1'b1);
    send(3'b000, 1'b1);
    for (int c = 0; c < 6; c++) begin
      send(3'b010, 1'b1);
      send(3'b011, 1'b1);
      send(3'b101, 1'b1);
      send(3'b000, 1'b1);
    end
    checks++; if (bus.cyc_count !== 8'd7 || bus.locked !== 1'b1) begin errors++; $display("FAIL async_pre: got cyc=%0d locked=%b expected 7/1", bus.cyc_count, bus.locked); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.locked !== 1'b0 || bus.err !== 1'b0 || bus.err_count !== 8'd0 || bus.cyc_count !== 8'd0) begin errors++; $display("FAIL async_clear: got locked=%b err=%b ecnt=%0d ccnt=%0d expected all 0", bus.locked, bus.err, bus.err_count, bus.cyc_count); end
    @(negedge clk);
    rst = 1'b1;
    send(3'b000, 1'b1);
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL async_relock_1: got %b expected 0", bus.locked); end
    send(3'b010, 1'b1);
    checks++; if (bus.locked !== 1'b1 || bus.cyc_count !== 8'd0) begin errors++; $display("FAIL async_relock_2: got locked=%b cyc=%0d expected 1/0", bus.locked, bus.cyc_count); end
  endtask

  initial begin
    test_reset();
    test_lock_and_cycle();
    test_single_error();
    test_idle();
    test_double_error();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequence_checker.md
SEQUENCE_CHECKER -- requirements
Module: sequence_checker

Interface
REQ-001 The module SHALL have parameter ERR_W, default 8, giving the width of the error counter.
REQ-002 The module SHALL have parameter CYC_W, default 8, giving the width of the cycle counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 in  input  3  received symbol from the 4-symbol sequence generator.
REQ-006 in_valid  input  1  qualifies in; ignored cycles change no state.
REQ-007 locked  output  1  registered; 1 while tracking the legal sequence.
REQ-008 err  output  1  registered one-cycle pulse on a sequence violation while locked.
REQ-009 err_count  output  ERR_W  registered violation count, saturating.
REQ-010 cyc_count  output  CYC_W  registered count of completed 4-symbol cycles, wrapping.

Function
REQ-011 Legal sequence SHALL be S0=000 -> S1=010 -> S2=011 -> S3=101 -> S0, repeating; every other 3-bit value is illegal.
REQ-012 FSM states SHALL be HUNT, VERIFY, LOCK, SUSPECT; internal register exp[2:0] holds the next expected symbol.
REQ-013 Only cycles with in_valid=1 SHALL be evaluated; with in_valid=0, state, exp and all outputs hold, except err, which is 0.
REQ-014 HUNT: a legal symbol SHALL set exp=next(in) and go to VERIFY; an illegal symbol SHALL keep HUNT.
REQ-015 VERIFY: in==exp SHALL advance exp and go to LOCK; any other legal symbol SHALL reload exp=next(in) and stay in VERIFY; an illegal symbol SHALL go to HUNT.
REQ-016 LOCK: in==exp SHALL advance exp; a mismatch SHALL go to SUSPECT, advance exp as if the symbol matched, pulse err, and increment err_count.
REQ-017 SUSPECT: in==exp SHALL advance exp and return to LOCK; a mismatch SHALL go to HUNT, pulse err, and increment err_count.
REQ-018 locked SHALL be 1 exactly when the registered state is LOCK or SUSPECT.
REQ-019 err, err_count, cyc_count and locked SHALL update on the clock edge that evaluates the symbol, so they are visible one cycle after the symbol is presented.
REQ-020 err_count SHALL saturate at 2^ERR_W-1; further violations still pulse err.
REQ-021 cyc_count SHALL increment, modulo 2^CYC_W, when a valid in==000 matches exp while in LOCK or SUSPECT.
REQ-022 The transition that enters LOCK SHALL NOT increment cyc_count, even if the matched symbol is 000.
REQ-023 A violation and a cycle completion cannot occur on the same edge; no priority rule is needed.

Reset
REQ-024 While rst=0, the block SHALL immediately hold state=HUNT, exp=000, locked=0, err=0, err_count=0, cyc_count=0, independent of clk.
REQ-025 Reset asserted mid-sequence SHALL discard all lock history; after release, the block re-acquires from HUNT.
REQ-026 The first edge after rst deasserts SHALL evaluate in normally.

Structure
REQ-027 A shared package seq_pkg SHALL hold the symbol constants S0..S3, the FSM state enum, and a next-symbol function (S0->S1->S2->S3->S0; illegal -> S0). The same package SHALL be usable by the generator.
REQ-028 One sub-module, sat_counter (parameterised width, inc, clr, saturating), SHALL implement err_count.
REQ-029 cyc_count SHALL be a plain wrapping counter.

Verification
REQ-030 Reset, then feed 000,010,011,101,000 with in_valid=1 -> locked=1 one cycle after the 010; cyc_count=1 after the final 000; err stays 0.
REQ-031 While locked and expecting 011, feed 111, then 101 -> err pulses once, err_count=1, locked stays 1, and the state returns to LOCK.
REQ-032 While locked, feed two consecutive wrong symbols -> err pulses twice, err_count=2, locked=0, and the state is HUNT.
REQ-033 While locked, insert 5 idle cycles (in_valid=0, in=111) between legal symbols -> no err and no state change; the lock is held.
REQ-034 With ERR_W=2, force 5 violations -> err_count stops at 3; err pulses all 5 times.
REQ-035 Drive rst=0 asynchronously between clock edges while locked with cyc_count=7 -> all outputs are 0 immediately; after release, re-lock requires 2 legal symbols.
